// File: rtl/adc_decimator.sv
// Boxcar averaging decimator: sums 2^log_window signed samples and emits their average.
// Optional build macro ROUNDING_EN selects round-half-up instead of floor on the average.
module adc_decimator #(
    parameter int DATA_PATH_WIDTH = 16,
    parameter int MAX_LOG2_WINDOW = 7
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              pipeline_flush,
    input  logic [1:0]                        cfg_address,
    input  logic [15:0]                       cfg_data,
    input  logic                              cfg_we,
    input  logic signed [DATA_PATH_WIDTH-1:0] data_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic signed [DATA_PATH_WIDTH-1:0] data_out,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int ACC_W = DATA_PATH_WIDTH + MAX_LOG2_WINDOW;
    localparam int LW_W  = $clog2(MAX_LOG2_WINDOW + 1);
    localparam int CNT_W = MAX_LOG2_WINDOW;

    logic [LW_W-1:0]              log_window;
    logic                         bypass;
    logic signed [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]             count;

    logic                         xfer;
    logic                         cfg_write;
    logic                         count_last;
    logic                         complete;
    logic signed [ACC_W-1:0]      sum;
    logic signed [DATA_PATH_WIDTH-1:0] result;
    logic                         unused_cfg_bits;

    assign unused_cfg_bits = ^cfg_data[15:3];

    // Handshake: a sample moves when in_valid & in_ready; an output moves when
    // out_valid & out_ready. Input stalls only while an output sits unconsumed.
    assign in_ready   = ~(out_valid & ~out_ready);
    assign xfer       = in_valid & in_ready;
    assign cfg_write  = cfg_we & (cfg_address == 2'd0 || cfg_address == 2'd1);
    assign count_last = (count == CNT_W'((1 << log_window) - 1));
    // A config write in the same cycle discards the accepted sample.
    assign complete   = xfer & ~cfg_write & (bypass | count_last);
    assign sum        = acc + {{MAX_LOG2_WINDOW{data_in[DATA_PATH_WIDTH-1]}}, data_in};

`ifdef ROUNDING_EN
    logic signed [ACC_W:0] biased;
    always_comb begin
        biased = {sum[ACC_W-1], sum}
               + (ACC_W+1)'(log_window == '0 ? 0 : (1 << (log_window - 1'b1)));
        result = DATA_PATH_WIDTH'(biased >>> log_window);
    end
`else
    always_comb begin
        result = DATA_PATH_WIDTH'(sum >>> log_window);
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            log_window <= '0;
            bypass     <= 1'b0;
            acc        <= '0;
            count      <= '0;
            data_out   <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (cfg_write) begin
                if (cfg_address == 2'd0) begin
                    if (int'(cfg_data[2:0]) > MAX_LOG2_WINDOW)
                        log_window <= LW_W'(MAX_LOG2_WINDOW);
                    else
                        log_window <= LW_W'(cfg_data[2:0]);
                end else begin
                    bypass <= cfg_data[0];
                end
            end

            if (pipeline_flush) begin
                acc       <= '0;
                count     <= '0;
                data_out  <= '0;
                out_valid <= 1'b0;
            end else begin
                if (complete) begin
                    data_out  <= bypass ? data_in : result;
                    out_valid <= 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end

                if (cfg_write || complete) begin
                    acc   <= '0;
                    count <= '0;
                end else if (xfer) begin
                    acc   <= sum;
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_decimator.sv
// Bench for adc_decimator: window-averaging model with pending-output queue plus literal checks.
module tb_adc_decimator;

    logic               clock = 1'b0;
    logic               reset;
    logic               pipeline_flush;
    logic [1:0]         cfg_address;
    logic [15:0]        cfg_data;
    logic               cfg_we;
    logic signed [15:0] data_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] data_out;
    logic               out_valid;
    logic               out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cycles = 0;
    logic signed [15:0] dut_last = '0;

    // model state
    logic [15:0] exp_q[$];
    longint      win[$];
    int          m_lw  = 0;
    bit          m_byp = 1'b0;

    adc_decimator dut (
        .clock(clock), .reset(reset), .pipeline_flush(pipeline_flush),
        .cfg_address(cfg_address), .cfg_data(cfg_data), .cfg_we(cfg_we),
        .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Average of n = 2^lw samples: floor, or round-half-up when ROUNDING_EN.
    function automatic longint window_avg(input longint s, input int lw);
        longint n, q;
        n = longint'(1) << lw;
`ifdef ROUNDING_EN
        if (lw > 0) s = s + n / 2;
`endif
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    always @(negedge reset) begin
        exp_q.delete();
        win.delete();
        m_lw  = 0;
        m_byp = 1'b0;
    end

    always @(posedge clock) begin : model
        bit     xfer, consumed, wr;
        longint s;
        if (reset) begin
            xfer     = in_valid && !(exp_q.size() > 0 && !out_ready);
            consumed = exp_q.size() > 0 && out_ready;
            wr       = cfg_we && cfg_address < 2;
            if (wr) begin
                if (cfg_address == 0) m_lw = (cfg_data[2:0] > 7) ? 7 : int'(cfg_data[2:0]);
                else                  m_byp = cfg_data[0];
                win.delete();
            end
            if (pipeline_flush) begin
                win.delete();
                exp_q.delete();
            end else begin
                if (consumed) void'(exp_q.pop_front());
                if (!wr && xfer) begin
                    if (m_byp) begin
                        exp_q.push_back(data_in);
                    end else begin
                        win.push_back(longint'(data_in));
                        if (win.size() == (1 << m_lw)) begin
                            s = 0;
                            foreach (win[i]) s = s + win[i];
                            exp_q.push_back(16'(window_avg(s, m_lw)));
                            win.delete();
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clock) begin
        check("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) check("data_out", data_out, $signed(exp_q[0]));
        check("in_ready", in_ready, !(exp_q.size() > 0 && !out_ready));
        if (out_valid) begin
            valid_cycles++;
            dut_last = data_out;
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic send(input logic signed [15:0] d, input logic ordy);
        in_valid  = 1'b1;
        data_in   = d;
        out_ready = ordy;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [15:0] d);
        cfg_we      = 1'b1;
        cfg_address = a;
        cfg_data    = d;
        step();
        cfg_we      = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        pipeline_flush = 1'b0;
        cfg_address = '0;
        cfg_data = '0;
        cfg_we = 1'b0;
        data_in = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clock);
        #1;
        reset = 1'b1;

        // 1,2,3,4 over a window of 4
        cfg(2'd0, 16'd2);
        valid_cycles = 0;
        send(1, 1); send(2, 1); send(3, 1); send(4, 1);
        step(); step(); step();
        check("win4_valid_cycles", valid_cycles, 1);
`ifdef ROUNDING_EN
        check("win4_pos", dut_last, 3);
`else
        check("win4_pos", dut_last, 2);
`endif

        send(-1, 1); send(-2, 1); send(-3, 1); send(-4, 1);
        step();
`ifdef ROUNDING_EN
        check("win4_neg", dut_last, -2);
`else
        check("win4_neg", dut_last, -3);
`endif

        // full-scale windows of 128
        cfg(2'd0, 16'd7);
        for (int i = 0; i < 128; i++) send(16'sd32767, 1);
        step();
        check("win128_max", dut_last, 32767);
        for (int i = 0; i < 128; i++) send(-16'sd32768, 1);
        step();
        check("win128_min", dut_last, -32768);

        // backpressure hold then release
        cfg(2'd0, 16'd2);
        send(5, 1); send(5, 1); send(5, 1); send(5, 0);
        in_valid = 1'b1; data_in = 16'sd100; out_ready = 1'b0;
        step(); step(); step();
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_data_out", data_out, 5);
        in_valid = 1'b0;
        send(100, 1); send(200, 1); send(300, 1); send(400, 1);
        step();
        check("after_stall", dut_last, 250);

        // flush discards partial window
        send(50, 1); send(60, 1);
        pipeline_flush = 1'b1;
        step();
        pipeline_flush = 1'b0;
        send(4, 1); send(8, 1); send(8, 1); send(4, 1);
        step();
        check("after_flush", dut_last, 6);

        // config write beats a same-cycle sample
        cfg(2'd0, 16'd1);
        send(10, 1);
        cfg_we = 1'b1; cfg_address = 2'd0; cfg_data = 16'd1;
        in_valid = 1'b1; data_in = 16'sd999;
        step();
        cfg_we = 1'b0; in_valid = 1'b0;
        send(20, 1); send(30, 1);
        step();
        check("cfg_wins", dut_last, 25);

        // bypass
        cfg(2'd1, 16'd1);
        send(7, 1);
        check("bypass_a", dut_last, 7);
        send(-9, 1);
        check("bypass_b", dut_last, -9);
        cfg(2'd1, 16'd0);

        // async reset while an output is pending
        cfg(2'd0, 16'd3);
        for (int i = 1; i <= 8; i++) send(16'(i * 10), 0);
        check("pend_valid", out_valid, 1);
        check("pend_data", data_out, 45);
        #2;
        reset = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_data_out", data_out, 0);
        check("async_in_ready", in_ready, 1);
        step();
        reset = 1'b1;
        send(77, 1);
        check("post_reset_pass", dut_last, 77);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
